// File: rtl/mvm_seq_ctrl_if.sv
// rtl/mvm_seq_ctrl_if.sv - word stream, result stream and datapath handshake bundle for mvm_seq_ctrl
interface mvm_seq_ctrl_if #(
    parameter int B = 8
);
    logic [B-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic           keep_matrix;
    logic [2*B-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           mvm_load_matrix;
    logic           mvm_load_vector;
    logic           mvm_start;
    logic [B-1:0]   mvm_data_in;
    logic           mvm_done;
    logic [2*B-1:0] mvm_data_out;
    logic           busy;
    logic           err;

    modport slave (
        input  in_data, in_valid, keep_matrix, out_ready, mvm_done, mvm_data_out,
        output in_ready, out_data, out_valid, mvm_load_matrix, mvm_load_vector,
               mvm_start, mvm_data_in, busy, err
    );

    modport master (
        output in_data, in_valid, keep_matrix, out_ready, mvm_done, mvm_data_out,
        input  in_ready, out_data, out_valid, mvm_load_matrix, mvm_load_vector,
               mvm_start, mvm_data_in, busy, err
    );
endinterface

// File: rtl/mvm_seq_ctrl.sv
// rtl/mvm_seq_ctrl.sv - sequencer feeding matrix/vector words to an MVM datapath and buffering its K results
module mvm_seq_ctrl #(
    parameter int K       = 20,
    parameter int B       = 8,
    parameter int OUT_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mvm_seq_ctrl_if.slave bus
);
    localparam int WCW = $clog2(K*K+1);
    localparam int CCW = $clog2(K+OUT_LAT+1);
    localparam int PW  = (K > 1) ? $clog2(K) : 1;
    localparam int NW  = $clog2(K+1);

    localparam logic [WCW-1:0] MAT_LAST = WCW'(K*K-1);
    localparam logic [WCW-1:0] VEC_LAST = WCW'(K-1);
    localparam logic [CCW-1:0] CAP_LAST = CCW'(OUT_LAT+K-2);
    localparam logic [CCW:0]   CAP_FROM = (CCW+1)'(OUT_LAT);
    localparam logic [CCW:0]   CAP_ONE  = (CCW+1)'(1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(K-1);

    typedef enum logic [3:0] {
        S_IDLE, S_PULSE_M, S_LOAD_M, S_PULSE_V, S_LOAD_V,
        S_WAIT_OUT, S_START, S_RUN, S_CAPTURE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WCW-1:0]  r_wcnt;
    logic [CCW-1:0]  r_ccnt;
    logic            r_mat_loaded;
    logic            r_err;

    logic [2*B-1:0]  r_mem [K];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [NW-1:0]   r_count;

    logic            w_in_ready;
    logic            w_load_m;
    logic            w_load_v;
    logic            w_start;
    logic [B-1:0]    w_data_in;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_empty;

    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = !w_fifo_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.in_valid)
                            w_next = (bus.keep_matrix && r_mat_loaded) ? S_PULSE_V : S_PULSE_M;
            S_PULSE_M:  w_next = S_LOAD_M;
            S_LOAD_M:   if (!bus.in_valid)          w_next = S_IDLE;
                        else if (r_wcnt == MAT_LAST) w_next = S_PULSE_V;
            S_PULSE_V:  w_next = S_LOAD_V;
            S_LOAD_V:   if (!bus.in_valid)          w_next = S_IDLE;
                        else if (r_wcnt == VEC_LAST) w_next = S_WAIT_OUT;
            // An empty FIFO here is what lets CAPTURE push all K results unconditionally.
            S_WAIT_OUT: if (w_fifo_empty) w_next = S_START;
            S_START:    w_next = S_RUN;
            S_RUN:      if (bus.mvm_done) w_next = S_CAPTURE;
            S_CAPTURE:  if (r_ccnt == CAP_LAST) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_load_m   = 1'b0;
        w_load_v   = 1'b0;
        w_start    = 1'b0;
        w_data_in  = '0;
        w_push     = 1'b0;
        case (r_state)
            S_PULSE_M: w_load_m = 1'b1;
            S_PULSE_V: w_load_v = 1'b1;
            S_LOAD_M, S_LOAD_V: begin
                w_in_ready = 1'b1;
                w_data_in  = bus.in_data;
            end
            S_START:   w_start = 1'b1;
            // The first OUT_LAT-1 capture cycles are the datapath's output latency.
            S_CAPTURE: w_push = (({1'b0, r_ccnt} + CAP_ONE) >= CAP_FROM);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt       <= '0;
            r_ccnt       <= '0;
            r_mat_loaded <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_PULSE_M, S_PULSE_V: r_wcnt <= '0;
                S_LOAD_M: begin
                    if (!bus.in_valid) begin
                        r_err        <= 1'b1;
                        r_mat_loaded <= 1'b0;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (r_wcnt == MAT_LAST) r_mat_loaded <= 1'b1;
                    end
                end
                S_LOAD_V: begin
                    if (!bus.in_valid) begin
                        r_err        <= 1'b1;
                        r_mat_loaded <= 1'b0;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_RUN:     r_ccnt <= '0;
                S_CAPTURE: r_ccnt <= r_ccnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.mvm_data_out;
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.mvm_load_matrix = w_load_m;
    assign bus.mvm_load_vector = w_load_v;
    assign bus.mvm_start       = w_start;
    assign bus.mvm_data_in     = w_data_in;
    assign bus.out_valid       = !w_fifo_empty;
    assign bus.out_data        = r_mem[r_rd_ptr];
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.err             = r_err;
endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb/tb_mvm_seq_ctrl.sv - scoreboard bench for mvm_seq_ctrl with a behavioural 2x2 MVM datapath
module tb_mvm_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mvm_seq_ctrl_if #(.B(8)) bus ();

    mvm_seq_ctrl #(.K(2), .B(8), .OUT_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q [$];
    int n_lm, n_lv, n_st, n_words;
    bit seen_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural datapath: latches words after each load pulse, answers start with done + K results.
    int dp_mode = 0, dp_idx = 0, dp_delay = -1, dp_out_idx = -1;
    int dp_mat [4];
    int dp_vec [2];
    logic [15:0] dp_res [2];

    always @(negedge clk) begin
        if (bus.mvm_load_matrix) begin
            dp_mode = 1; dp_idx = 0;
        end else if (bus.mvm_load_vector) begin
            dp_mode = 2; dp_idx = 0;
        end else if (bus.in_valid && bus.in_ready) begin
            if (dp_mode == 1 && dp_idx < 4) dp_mat[dp_idx] = int'(bus.mvm_data_in);
            else if (dp_mode == 2 && dp_idx < 2) dp_vec[dp_idx] = int'(bus.mvm_data_in);
            dp_idx++;
        end
        bus.mvm_done = 1'b0;
        if (dp_out_idx >= 0) begin
            bus.mvm_data_out = dp_res[dp_out_idx];
            dp_out_idx = (dp_out_idx == 1) ? -1 : dp_out_idx + 1;
        end else begin
            bus.mvm_data_out = 16'hbeef;
        end
        if (dp_delay > 0) dp_delay--;
        else if (dp_delay == 0) begin
            bus.mvm_done = 1'b1;
            dp_delay = -1;
            dp_out_idx = 0;
        end
        if (bus.mvm_start) begin
            for (int r = 0; r < 2; r++)
                dp_res[r] = 16'(dp_mat[2*r] * dp_vec[0] + dp_mat[2*r+1] * dp_vec[1]);
            dp_delay = 4;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mvm_load_matrix) n_lm++;
            if (bus.mvm_load_vector) n_lv++;
            if (bus.mvm_start) n_st++;
            if (bus.in_valid && bus.in_ready) n_words++;
            if (bus.out_valid) seen_ov = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 32'(exp_q.size()), 32'd1);
                else check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_word(input int w);
        bit ok = 1'b0;
        bus.in_data  = 8'(w);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("in_ready_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input bit keep, input bit load_mat, input int m0, input int m1,
                           input int m2, input int m3, input int v0, input int v1,
                           input bit expect_out);
        if (expect_out) begin
            exp_q.push_back(16'(m0 * v0 + m1 * v1));
            exp_q.push_back(16'(m2 * v0 + m3 * v1));
        end
        n_lm = 0; n_lv = 0; n_st = 0; n_words = 0;
        bus.keep_matrix = keep;
        if (load_mat) begin
            send_word(m0); send_word(m1); send_word(m2); send_word(m3);
        end
        send_word(v0); send_word(v1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) begin ok = 1'b1; break; end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.keep_matrix = 1'b0;
        bus.out_ready = 1'b1; bus.mvm_done = 1'b0; bus.mvm_data_out = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready",  32'(bus.in_ready), 0);
        check("rst_err",       32'(bus.err), 0);
        check("rst_load_m",    32'(bus.mvm_load_matrix), 0);
        check("rst_load_v",    32'(bus.mvm_load_vector), 0);
        check("rst_start",     32'(bus.mvm_start), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Fresh job: full matrix + vector.
        run_job(1'b0, 1'b1, 1, 2, 3, 4, 5, 6, 1'b1);
        wait_drain("job1_drain");
        check("job1_load_m", 32'(n_lm), 1);
        check("job1_load_v", 32'(n_lv), 1);
        check("job1_start",  32'(n_st), 1);
        check("job1_words",  32'(n_words), 6);
        check("job1_err",    32'(bus.err), 0);

        // Matrix reuse: only the vector segment.
        run_job(1'b1, 1'b0, 1, 2, 3, 4, 1, 1, 1'b1);
        wait_drain("job2_drain");
        check("job2_load_m", 32'(n_lm), 0);
        check("job2_words",  32'(n_words), 2);
        check("job2_start",  32'(n_st), 1);

        // Segment broken after 2 matrix words.
        n_st = 0;
        bus.keep_matrix = 1'b0;
        send_word(9); send_word(9);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("brk_err_pre",  32'(bus.err), 0);
        @(negedge clk);
        check("brk_err",      32'(bus.err), 1);
        check("brk_busy",     32'(bus.busy), 0);
        repeat (10) @(negedge clk);
        check("brk_no_start", 32'(n_st), 0);
        @(posedge clk); #1;
        // mat_loaded was cleared, so keep_matrix must not skip the matrix.
        run_job(1'b1, 1'b1, 2, 0, 0, 3, 4, 5, 1'b1);
        wait_drain("job3_drain");
        check("job3_load_m",  32'(n_lm), 1);
        check("job3_err_sticky", 32'(bus.err), 1);

        // Back-pressure: second job must wait for the FIFO to empty.
        bus.out_ready = 1'b0;
        run_job(1'b0, 1'b1, 1, 0, 1, 1, 2, 3, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) begin ok = 1'b1; break; end
        end
        check("jobA_done", 32'(ok), 1);
        check("jobA_held", 32'(bus.out_valid), 1);
        @(posedge clk); #1;
        run_job(1'b1, 1'b0, 1, 0, 1, 1, 10, 20, 1'b1);
        repeat (8) @(negedge clk);
        check("wait_busy",     32'(bus.busy), 1);
        check("wait_no_start", 32'(n_st), 0);
        check("wait_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_drain("jobB_drain");
        check("jobB_start", 32'(n_st), 1);

        // Reset while the datapath runs; its late done must be ignored.
        run_job(1'b0, 1'b1, 1, 2, 3, 4, 1, 0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mvm_start) begin ok = 1'b1; break; end
        end
        check("rr_start_seen", 32'(ok), 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rr_busy",      32'(bus.busy), 0);
        check("rr_out_valid", 32'(bus.out_valid), 0);
        check("rr_err",       32'(bus.err), 0);
        seen_ov = 1'b0;
        repeat (15) @(negedge clk);
        check("rr_no_output", 32'(seen_ov), 0);
        check("rr_idle",      32'(bus.busy), 0);
        @(posedge clk); #1;
        run_job(1'b1, 1'b1, 1, 2, 3, 4, 1, 1, 1'b1);
        wait_drain("job5_drain");
        check("job5_load_m", 32'(n_lm), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mvm_seq_ctrl.md
MVM_SEQ_CTRL -- requirements
Module: mvm_seq_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- K, 20, matrix dimension; matrix is KxK, vector and result are K.
- B, 8, input word width in bits.
- OUT_LAT, 1, cycles from mvm_done high to the first valid result on mvm_data_out.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock; reset, in, 1, reset, synchronous, active-high.
- in_data, in, B, matrix/vector word stream.
- in_valid, in, 1, upstream word valid.
- in_ready, out, 1, word accepted when in_valid & in_ready.
- keep_matrix, in, 1, sampled at job start: reuse the loaded matrix and skip the matrix segment.
- out_data, out, 2B, result stream head.
- out_valid, out, 1, result available.
- out_ready, in, 1, downstream accepts result.
- mvm_load_matrix, out, 1, one-cycle pulse to the datapath.
- mvm_load_vector, out, 1, one-cycle pulse to the datapath.
- mvm_start, out, 1, one-cycle pulse to the datapath.
- mvm_data_in, out, B, datapath operand word.
- mvm_done, in, 1, datapath completion pulse.
- mvm_data_out, in, 2B, datapath result word.
- busy, out, 1, state != IDLE.
- err, out, 1, sticky protocol error.

Function
REQ-003 FSM states: IDLE, PULSE_M, LOAD_M, PULSE_V, LOAD_V, WAIT_OUT, START, RUN, CAPTURE; all transitions on the clk edge.
REQ-004 IDLE with in_valid=1: if keep_matrix=1 and mat_loaded=1, go to PULSE_V; otherwise go to PULSE_M. No word is accepted in IDLE.
REQ-005 PULSE_M: mvm_load_matrix=1, in_ready=0; next state LOAD_M.
REQ-006 LOAD_M: in_ready=1; mvm_data_in=in_data combinationally; one word per cycle; after exactly K*K accepted words go to PULSE_V and set mat_loaded=1.
REQ-007 PULSE_V: mvm_load_vector=1, in_ready=0; next state LOAD_V.
REQ-008 LOAD_V: same rules as LOAD_M with a count of K words; then go to WAIT_OUT.
REQ-009 Segment contract: in_valid=0 in any LOAD_M or LOAD_V cycle sets err=1, clears mat_loaded, and returns to IDLE; the datapath is not started.
REQ-010 WAIT_OUT: remain until the result FIFO is empty, then go to START. This guarantees K results always fit.
REQ-011 START: mvm_start=1 for one cycle; next state RUN.
REQ-012 RUN: wait for mvm_done=1, then go to CAPTURE. mvm_done in any other state is ignored.
REQ-013 CAPTURE: skip OUT_LAT-1 cycles, then push mvm_data_out into the FIFO on K consecutive cycles (sign-extension not applied; 2B bits pass through), then go to IDLE. OUT_LAT=1 means push starts the cycle after done is sampled.
REQ-014 Result FIFO: depth K, width 2B; out_valid = !empty; out_data = head; pop on out_valid & out_ready.
REQ-015 FIFO simultaneous push and pop is legal; count is unchanged. Pointers wrap modulo K.
REQ-016 FIFO pop continues in all states, so draining overlaps loading of the next job.
REQ-017 in_ready=0 in every state except LOAD_M and LOAD_V.
REQ-018 mvm_data_in=0 when not in LOAD_M or LOAD_V.
REQ-019 Counters: word counter width $clog2(K*K+1), cleared on every segment entry; capture counter width $clog2(K+OUT_LAT+1).
REQ-020 err stays high until reset and does not block later jobs.

Reset
REQ-021 On reset=1 the following hold the next cycle:
- state=IDLE;
- all counters=0;
- mat_loaded=0, err=0;
- FIFO empty, out_valid=0;
- mvm_load_matrix=0, mvm_load_vector=0, mvm_start=0;
- in_ready=0, busy=0.
REQ-022 Reset mid-job (any state) aborts the job; FIFO contents are discarded; the next job after reset always loads the matrix.

Verification (K=2, B=8, OUT_LAT=1, behavioural datapath model)
REQ-023 Stream 1,2,3,4,5,6 with in_valid held high and keep_matrix=0 -> one load_matrix pulse, 4 words accepted, one load_vector pulse, 2 words, one start pulse; out stream 17, 39; err=0.
REQ-024 Second job with keep_matrix=1, vector 1,1 -> no mvm_load_matrix pulse, exactly 2 words accepted; outputs 3, 7.
REQ-025 keep_matrix=1 directly after reset -> matrix segment is loaded anyway (mvm_load_matrix pulses).
REQ-026 Drop in_valid after the 2nd matrix word -> err=1 next cycle, state IDLE, mvm_start never pulses; a following full job still completes with correct results.
REQ-027 out_ready=0 while a second job loads -> the controller holds in WAIT_OUT with mvm_start=0 until both old results are popped; then it starts and outputs are in order.
REQ-028 Assert reset during RUN -> busy=0, out_valid=0 next cycle; a later mvm_done is ignored.
